rv_timer: RTL and testbench

Machine timer for the uRV core: a prescaled up-counter with a compare register. It generates the single-cycle timer tick that drives the `exp_tick_i` input of the exception unit, which performs the masking, pending and trap entry. Software programs it through a small 4-register word port that the system bus or CSR glue decodes. Counting is free-running and independent of pipeline stalls.

---
 rtl/rv_timer.sv | 126 ++++++++++++
 tb/tb_rv_timer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_timer.sv
// Machine timer for the uRV core: prescaled 32-bit up-counter with compare,
// producing a registered one-cycle tick and a sticky PEND flag.
module rv_timer #(
  parameter int g_prescaler_width = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  tm_addr_i,
  input  logic        tm_wr_i,
  input  logic [31:0] tm_wdata_i,
  output logic [31:0] tm_rdata_o,
  output logic        tick_o,
  output logic [31:0] count_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic                         r_per;
  logic                         r_pend;
  logic                         r_tick;
  logic [g_prescaler_width-1:0] r_prescale;
  logic [g_prescaler_width-1:0] r_ps_cnt;
  logic [31:0]                  r_compare;
  logic [31:0]                  r_count;

  logic        w_ctrl_wr;
  logic        w_ps_stb;
  logic        w_match;
  logic        w_start;
  logic [31:0] w_prescale_ext;

  assign w_ctrl_wr      = tm_wr_i && (tm_addr_i == 2'd0);
  assign w_ps_stb       = (r_state == ST_RUN) && (r_ps_cnt == r_prescale);
  assign w_match        = w_ps_stb && (r_count == r_compare);
  assign w_start        = w_ctrl_wr && tm_wdata_i[0] && (r_state == ST_IDLE);
  assign w_prescale_ext = 32'(r_prescale);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A CTRL write overrides the one-shot auto-disable in the same cycle.
  always_comb begin
    w_state_next = r_state;
    if (w_ctrl_wr) begin
      w_state_next = tm_wdata_i[0] ? ST_RUN : ST_IDLE;
    end else if (w_match && !r_per) begin
      w_state_next = ST_IDLE;
    end else begin
      w_state_next = r_state;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_per      <= 1'b0;
      r_pend     <= 1'b0;
      r_tick     <= 1'b0;
      r_prescale <= '0;
      r_ps_cnt   <= '0;
      r_compare  <= 32'hFFFF_FFFF;
      r_count    <= 32'd0;
    end else begin
      r_tick <= w_match;

      if (w_ctrl_wr) begin
        r_per <= tm_wdata_i[1];
      end

      if (w_match) begin
        r_pend <= 1'b1;
      end else if (w_ctrl_wr && tm_wdata_i[2]) begin
        r_pend <= 1'b0;
      end

      if (tm_wr_i && (tm_addr_i == 2'd1)) begin
        r_prescale <= tm_wdata_i[g_prescaler_width-1:0];
      end

      if (tm_wr_i && (tm_addr_i == 2'd2)) begin
        r_compare <= tm_wdata_i;
      end

      if (w_start || w_ps_stb) begin
        r_ps_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_ps_cnt <= r_ps_cnt + g_prescaler_width'(1);
      end

      // Software writes win over both the periodic reload and the increment.
      if (tm_wr_i && (tm_addr_i == 2'd3)) begin
        r_count <= tm_wdata_i;
      end else if (w_match) begin
        if (r_per) begin
          r_count <= 32'd0;
        end
      end else if (w_ps_stb) begin
        r_count <= r_count + 32'd1;
      end
    end
  end

  always_comb begin
    tm_rdata_o = 32'd0;
    case (tm_addr_i)
      2'd0:    tm_rdata_o = {29'd0, r_pend, r_per, (r_state == ST_RUN)};
      2'd1:    tm_rdata_o = w_prescale_ext;
      2'd2:    tm_rdata_o = r_compare;
      2'd3:    tm_rdata_o = r_count;
      default: tm_rdata_o = 32'd0;
    endcase
  end

  assign tick_o  = r_tick;
  assign count_o = r_count;

endmodule

// File: tb/tb_rv_timer.sv
// Self-checking bench for rv_timer: directed vector table, hand-written
// corner sequences, and random register traffic against a reference model.
module tb_rv_timer;

  localparam int          W     = 16;
  localparam logic [31:0] PMASK = 32'h0000_FFFF;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [1:0]  tm_addr_i = 2'd0;
  logic        tm_wr_i = 1'b0;
  logic [31:0] tm_wdata_i = 32'd0;
  logic [31:0] tm_rdata_o;
  logic        tick_o;
  logic [31:0] count_o;

  int n_cmp = 0;
  int n_fail = 0;

  rv_timer #(.g_prescaler_width(W)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .tm_addr_i  (tm_addr_i),
    .tm_wr_i    (tm_wr_i),
    .tm_wdata_i (tm_wdata_i),
    .tm_rdata_o (tm_rdata_o),
    .tick_o     (tick_o),
    .count_o    (count_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: architectural registers plus "cycles spent in the
  // current count step"; one call advances one clock per the timer rules.
  logic        m_en, m_per, m_pend, m_tick;
  logic [31:0] m_pre, m_cmp, m_cnt, m_ps;

  task automatic m_reset();
    m_en = 1'b0; m_per = 1'b0; m_pend = 1'b0; m_tick = 1'b0;
    m_pre = 32'd0; m_cmp = 32'hFFFF_FFFF; m_cnt = 32'd0; m_ps = 32'd0;
  endtask

  task automatic model_step(input logic wr, input logic [1:0] a, input logic [31:0] d);
    logic        step, hit;
    logic        n_en, n_per, n_pend;
    logic [31:0] n_pre, n_cmp, n_cnt, n_ps;
    step   = m_en && (m_ps == m_pre);
    hit    = step && (m_cnt == m_cmp);
    n_en   = m_en; n_per = m_per; n_pend = m_pend || hit;
    n_pre  = m_pre; n_cmp = m_cmp; n_cnt = m_cnt; n_ps = m_ps;
    if (m_en) n_ps = step ? 32'd0 : m_ps + 32'd1;
    if (hit) begin
      if (m_per) n_cnt = 32'd0;
      else n_en = 1'b0;
    end else if (step) begin
      n_cnt = m_cnt + 32'd1;
    end
    if (wr) begin
      case (a)
        2'd0: begin
          if (d[0] && !m_en) n_ps = 32'd0;
          n_en  = d[0];
          n_per = d[1];
          if (d[2] && !hit) n_pend = 1'b0;
        end
        2'd1:    n_pre = d & PMASK;
        2'd2:    n_cmp = d;
        default: n_cnt = d;
      endcase
    end
    m_en = n_en; m_per = n_per; m_pend = n_pend; m_tick = hit;
    m_pre = n_pre; m_cmp = n_cmp; m_cnt = n_cnt; m_ps = n_ps;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_pend, m_per, m_en};
      2'd1:    return m_pre;
      2'd2:    return m_cmp;
      default: return m_cnt;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check at the next falling edge.
  task automatic cyc(input logic wr, input logic [1:0] a, input logic [31:0] d);
    tm_wr_i = wr; tm_addr_i = a; tm_wdata_i = d;
    @(posedge clk_i);
    model_step(wr, a, d);
    @(negedge clk_i);
    chk("model_count", count_o, m_cnt);
    chk("model_tick", {31'd0, tick_o}, {31'd0, m_tick});
    chk("model_rdata", tm_rdata_o, model_read(a));
    tm_wr_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    m_reset();
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] e_count;
    logic        e_tick;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tv[$];

  initial begin
    logic [31:0] held, prev;
    int          ticks;
    bit          found;

    // Periodic mode, PRESCALE=0, COMPARE=3: CTRL=3 written at edge 0.
    tv.push_back('{1'b1, 2'd1, 32'd0, 32'd0, 1'b0, 32'd0});
    tv.push_back('{1'b1, 2'd2, 32'd3, 32'd0, 1'b0, 32'd3});
    tv.push_back('{1'b1, 2'd3, 32'd0, 32'd0, 1'b0, 32'd0});
    tv.push_back('{1'b1, 2'd0, 32'd3, 32'd0, 1'b0, 32'd3});
    for (int k = 2; k <= 13; k++)
      tv.push_back('{1'b0, 2'd3, 32'd0, 32'((k - 1) % 4), (k % 4 == 1), 32'((k - 1) % 4)});
    tv.push_back('{1'b0, 2'd0, 32'd0, 32'd1, 1'b0, 32'd7});
    tv.push_back('{1'b1, 2'd0, 32'd7, 32'd2, 1'b0, 32'd3});
    tv.push_back('{1'b0, 2'd0, 32'd0, 32'd3, 1'b0, 32'd3});
    tv.push_back('{1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 32'd7});

    m_reset();
    tm_addr_i = 2'd2;
    #12;
    chk("rst_count", count_o, 32'd0);
    chk("rst_tick", {31'd0, tick_o}, 32'd0);
    chk("rst_compare", tm_rdata_o, 32'hFFFF_FFFF);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cyc(1'b0, 2'd0, 32'd0);
    chk("post_rst_tick", {31'd0, tick_o}, 32'd0);

    foreach (tv[i]) begin
      cyc(tv[i].wr, tv[i].addr, tv[i].wdata);
      chk($sformatf("vec%0d_count", i), count_o, tv[i].e_count);
      chk($sformatf("vec%0d_tick", i), {31'd0, tick_o}, {31'd0, tv[i].e_tick});
      chk($sformatf("vec%0d_rdata", i), tm_rdata_o, tv[i].e_rdata);
    end

    // Asynchronous reset mid-cycle while running with COUNT=5.
    cyc(1'b1, 2'd1, 32'd100);
    cyc(1'b1, 2'd2, 32'hFFFF_FFFF);
    cyc(1'b1, 2'd3, 32'd5);
    cyc(1'b1, 2'd0, 32'd1);
    cyc(1'b0, 2'd2, 32'd0);
    chk("pre_rst_count", count_o, 32'd5);
    #2;
    rst_n_i = 1'b0;
    m_reset();
    #1;
    chk("arst_count", count_o, 32'd0);
    chk("arst_tick", {31'd0, tick_o}, 32'd0);
    chk("arst_compare", tm_rdata_o, 32'hFFFF_FFFF);
    tm_addr_i = 2'd0;
    #1;
    chk("arst_ctrl", tm_rdata_o, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cyc(1'b0, 2'd0, 32'd0);
    chk("arst_first_tick", {31'd0, tick_o}, 32'd0);

    // Prescaler: PRESCALE=2, COMPARE=1, periodic.
    cyc(1'b1, 2'd1, 32'd2);
    cyc(1'b1, 2'd2, 32'd1);
    cyc(1'b1, 2'd3, 32'd0);
    cyc(1'b1, 2'd0, 32'd3);
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) cyc(1'b0, 2'd3, 32'd0);
      chk("ps_count", count_o, 32'((k / 3) % 2));
      chk("ps_tick", {31'd0, tick_o}, {31'd0, (k > 0) && (k % 6 == 0)});
    end

    // One-shot: COMPARE=2, exactly one tick, then idle with COUNT=2.
    cyc(1'b1, 2'd0, 32'd0);
    cyc(1'b1, 2'd1, 32'd0);
    cyc(1'b1, 2'd2, 32'd2);
    cyc(1'b1, 2'd3, 32'd0);
    cyc(1'b1, 2'd0, 32'd5);
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 2'd0, 32'd0);
      ticks += int'(tick_o);
    end
    chk("os_ticks", 32'(ticks), 32'd1);
    chk("os_en", tm_rdata_o & 32'd1, 32'd0);
    chk("os_count", count_o, 32'd2);

    // Wrap: 0xFFFFFFFF -> 0, then match on 0.
    cyc(1'b1, 2'd3, 32'hFFFF_FFFF);
    cyc(1'b1, 2'd2, 32'd0);
    cyc(1'b1, 2'd1, 32'd0);
    cyc(1'b1, 2'd0, 32'd3);
    chk("wrap_c1", count_o, 32'hFFFF_FFFF);
    cyc(1'b0, 2'd3, 32'd0);
    chk("wrap_c2", count_o, 32'd0);
    chk("wrap_t2", {31'd0, tick_o}, 32'd0);
    cyc(1'b0, 2'd3, 32'd0);
    chk("wrap_t3", {31'd0, tick_o}, 32'd1);
    chk("wrap_c3", count_o, 32'd0);

    // Collision: COUNT write on a matching strobe.
    cyc(1'b1, 2'd2, 32'd3);
    cyc(1'b1, 2'd3, 32'd0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (count_o == 32'd3) found = 1'b1;
      else cyc(1'b0, 2'd3, 32'd0);
    end
    chk("coll_reach3", {31'd0, found}, 32'd1);
    cyc(1'b1, 2'd3, 32'd10);
    chk("coll_tick", {31'd0, tick_o}, 32'd1);
    chk("coll_count", count_o, 32'd10);

    // Disabled hold, then re-enable restarts the prescaler at 0.
    cyc(1'b1, 2'd2, 32'd1000);
    cyc(1'b1, 2'd1, 32'd3);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      prev = count_o;
      cyc(1'b0, 2'd3, 32'd0);
      if (count_o != prev) found = 1'b1;
    end
    chk("hold_step_seen", {31'd0, found}, 32'd1);
    cyc(1'b1, 2'd0, 32'd0);
    held = count_o;
    cyc(1'b1, 2'd1, 32'd0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 2'd3, 32'd0);
      chk("hold_count", count_o, held);
      chk("hold_tick", {31'd0, tick_o}, 32'd0);
    end
    cyc(1'b1, 2'd1, 32'd3);
    cyc(1'b1, 2'd0, 32'd1);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) cyc(1'b0, 2'd3, 32'd0);
      chk("resume_count", count_o, (k == 4) ? held + 32'd1 : held);
    end

    // Random register traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [1:0]  a;
      logic [31:0] d;
      a = 2'($urandom_range(0, 3));
      case (a)
        2'd0:    d = ($urandom() & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7))
                     | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
        2'd1:    d = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        2'd2:    d = 32'($urandom_range(0, 6));
        default: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1))
                                                 : 32'($urandom_range(0, 6));
      endcase
      cyc($urandom_range(0, 7) < 2, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
